gray_step_monitor: RTL and testbench
====================================

Name: gray_step_monitor

Overview:
Downstream consumer of the 3-bit Gray code sequence generator. Samples the Gray code stream, converts each sample to binary, and checks that consecutive samples differ by exactly one count. Runs a lock/fault state machine and keeps a saturating error count, for use as a sequence integrity checker and as a binary position source for later stages.

Parameters:
WIDTH, 3, Gray/binary code width.
LOCK_COUNT, 4, consecutive good forward steps needed to declare lock (1..15).
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  reset, asynchronous, active-high.
in_valid  input  1  gray_in is sampled this cycle.
gray_in  input  WIDTH  Gray-coded input value.
clr_err  input  1  synchronous clear of err_cnt.
bin_out  output  WIDTH  registered binary value of the last sample.
bin_valid  output  1  one-cycle pulse; bin_out updated.
step_fwd  output  1  one-cycle pulse; last sample was a +1 step.
step_rev  output  1  one-cycle pulse; last sample was a -1 step (feature only).
step_err  output  1  one-cycle pulse; illegal step detected.
locked  output  1  high while FSM is in LOCKED.
err_cnt  output  ERR_CNT_W  saturating count of illegal steps.
state_out  output  2  current FSM state encoding.

Behaviour:
- Reset values: all outputs 0. State IDLE. prev register 0. good_cnt 0.
- Latency: outputs are registered and update on the edge that samples in_valid=1, so they are visible 1 cycle after the input.
- in_valid=0 cycles: no state, counter or output change, except that pulses drop to 0.
- Conversion: b[MSB]=g[MSB]; b[i]=b[i+1]^g[i].
- delta = (bin_new - prev) mod 2^WIDTH.
  - delta 0: hold. No pulse except bin_valid. No state change.
  - delta 1: forward step, including wrap from max to 0.
  - delta 2^WIDTH-1: reverse step.
  - Any other delta: illegal.
- Every valid sample updates prev and bin_out, and asserts bin_valid.
- FSM states: IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3.
  - IDLE: the first valid sample seeds prev, with no step classification. Next state ACQUIRE, good_cnt=0.
  - ACQUIRE: a forward step increments good_cnt. When good_cnt reaches LOCK_COUNT, go to LOCKED. An illegal step sets good_cnt=0, pulses step_err, increments err_cnt, and stays in ACQUIRE.
  - LOCKED: a forward step stays LOCKED. An illegal step goes to FAULT, pulses step_err, and increments err_cnt.
  - FAULT: the next valid sample only re-seeds prev, with no classification and no error. Next state ACQUIRE, good_cnt=0.
- err_cnt saturates at all-ones.
- clr_err has priority: the counter goes to 0. If an error occurs in the same cycle, the result is 1.
- Reset mid-operation returns everything to IDLE and zero immediately; no partial state survives.

Optional Feature:
Macro GRAY_BIDIR_EN.
- Defined: a reverse step is legal. It pulses step_rev and counts toward lock like a forward step.
- Undefined: a reverse step is illegal and is handled as above. step_rev is tied to 0.

Decomposition:
- Package gray_pkg holds:
  - monitor state enum typedef (2-bit),
  - default WIDTH,
  - state encodings.
- One sub-module, gray_to_bin: combinational, parameterised by WIDTH, used for the conversion.

Test Plan:
- Lock-up (LOCK_COUNT=4): reset, then samples 000,001,011,010,110 on consecutive cycles.
  - bin_out 0,1,2,3,4, with bin_valid each cycle.
  - locked=1 one cycle after the 110 sample; step_err never pulses; err_cnt=0.
- Wrap: locked, then samples 101,100,000 (bin 6,7,0).
  - step_fwd pulses 3 times; locked stays 1; err_cnt unchanged.
- Skip: locked at 010 (bin 3), then sample 111 (bin 5).
  - step_err pulse, err_cnt=1, locked=0, state_out=3.
  - Next sample 101 gives state_out=1 and no error.
- Reverse: locked at 010, then sample 011 (bin 2).
  - Macro undefined: step_err pulse, state_out=3.
  - Macro defined: step_rev pulse, locked stays 1.
- Hold/gap: repeat sample 011, and 3 cycles of in_valid=0.
  - No step pulses; state and err_cnt unchanged; bin_valid only on valid cycles.
- Saturation/clear/reset (ERR_CNT_W=2): 5 illegal steps give err_cnt=3.
  - clr_err with a simultaneous illegal step gives err_cnt=1.
  - Asserting reset while locked forces all outputs to 0 and state_out=0 asynchronously.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray step monitor: default code width,
// monitor FSM state encodings and step classification.
package gray_pkg;

    localparam int GRAY_WIDTH = 3;

    // Monitor FSM; encodings are visible on state_out.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } mon_state_e;

    // Relation of a new sample to the previous one, modulo 2^WIDTH.
    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_FWD,
        STEP_REV,
        STEP_ILLEGAL
    } step_e;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// the Gray bit at that position and the binary bit just above it.
module gray_to_bin #(
    parameter int WIDTH = gray_pkg::GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic [WIDTH-1:0] bin;

    // Ripple the XOR chain from the MSB down.
    always_comb begin
        bin            = '0;
        bin[WIDTH-1]   = gray_i[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray_i[i];
        end
    end

    assign bin_o = bin;

endmodule

// File: rtl/gray_step_monitor.sv
// Gray step monitor: converts a sampled Gray stream to binary, classifies
// each step against the previous sample, runs an IDLE/ACQUIRE/LOCKED/FAULT
// lock machine and keeps a saturating count of illegal steps.
// Build option: define GRAY_BIDIR_EN to accept -1 steps as legal motion
// (pulsing step_rev); otherwise a -1 step is an illegal step.
module gray_step_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH      = GRAY_WIDTH,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 step_fwd,
    output logic                 step_rev,
    output logic                 step_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           state_out
);

    localparam int GOOD_W = 4;

    mon_state_e           state_q, state_d;
    // prev doubles as bin_out: every valid sample updates both identically.
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic [GOOD_W-1:0]    good_q, good_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 bin_valid_q, bin_valid_d;
    logic                 step_fwd_q, step_fwd_d;
    logic                 step_err_q, step_err_d;
    logic                 err_hit;

    logic [WIDTH-1:0]     bin_new;
    logic [WIDTH-1:0]     delta;
    step_e                step_kind;
    logic                 advance;
    logic                 illegal;

    gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
        .gray_i (gray_in),
        .bin_o  (bin_new)
    );

    // Classify the new sample relative to the previous one (wraps mod 2^WIDTH).
    always_comb begin
        delta = bin_new - prev_q;
        if (delta == '0)
            step_kind = STEP_HOLD;
        else if (delta == WIDTH'(1))
            step_kind = STEP_FWD;
        else if (delta == '1)
            step_kind = STEP_REV;
        else
            step_kind = STEP_ILLEGAL;
    end

`ifdef GRAY_BIDIR_EN
    assign advance = (step_kind == STEP_FWD) || (step_kind == STEP_REV);
    assign illegal = (step_kind == STEP_ILLEGAL);
`else
    assign advance = (step_kind == STEP_FWD);
    assign illegal = (step_kind == STEP_REV) || (step_kind == STEP_ILLEGAL);
`endif

`ifdef GRAY_BIDIR_EN
    logic step_rev_q, step_rev_d;
`endif

    // Next-state logic for the lock FSM, lock progress, pulses and error count.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves a signal unassigned, which would infer a latch.
        state_d     = state_q;
        prev_d      = prev_q;
        good_d      = good_q;
        bin_valid_d = 1'b0;
        step_fwd_d  = 1'b0;
        step_err_d  = 1'b0;
        err_hit     = 1'b0;
`ifdef GRAY_BIDIR_EN
        step_rev_d  = 1'b0;
`endif

        if (in_valid) begin
            prev_d      = bin_new;
            bin_valid_d = 1'b1;
            unique case (state_q)
                // First sample after reset or a fault only seeds prev.
                ST_IDLE, ST_FAULT: begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
                ST_ACQUIRE: begin
                    if (advance) begin
                        step_fwd_d = (step_kind == STEP_FWD);
`ifdef GRAY_BIDIR_EN
                        step_rev_d = (step_kind == STEP_REV);
`endif
                        good_d = good_q + GOOD_W'(1);
                        if (good_q == GOOD_W'(LOCK_COUNT - 1))
                            state_d = ST_LOCKED;
                    end else if (illegal) begin
                        good_d  = '0;
                        err_hit = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (advance) begin
                        step_fwd_d = (step_kind == STEP_FWD);
`ifdef GRAY_BIDIR_EN
                        step_rev_d = (step_kind == STEP_REV);
`endif
                    end else if (illegal) begin
                        state_d = ST_FAULT;
                        err_hit = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        step_err_d = err_hit;

        // Clear wins over increment, but an error in the same cycle still counts.
        if (clr_err)
            err_d = ERR_CNT_W'(err_hit);
        else if (err_hit && (err_q != {ERR_CNT_W{1'b1}}))
            err_d = err_q + ERR_CNT_W'(1);
        else
            err_d = err_q;
    end

    // State, sample and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            good_q      <= '0;
            err_q       <= '0;
            bin_valid_q <= 1'b0;
            step_fwd_q  <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_q      <= good_d;
            err_q       <= err_d;
            bin_valid_q <= bin_valid_d;
            step_fwd_q  <= step_fwd_d;
            step_err_q  <= step_err_d;
        end
    end

`ifdef GRAY_BIDIR_EN
    // Reverse-step pulse register, present only when reverse motion is legal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            step_rev_q <= 1'b0;
        else
            step_rev_q <= step_rev_d;
    end

    assign step_rev = step_rev_q;
`else
    assign step_rev = 1'b0;
`endif

    assign bin_out   = prev_q;
    assign bin_valid = bin_valid_q;
    assign step_fwd  = step_fwd_q;
    assign step_err  = step_err_q;
    assign locked    = (state_q == ST_LOCKED);
    assign err_cnt   = err_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Testbench for gray_step_monitor: a step-rule model checked against the DUT
// every cycle, plus directed samples with hand-computed expectations.
module tb_gray_step_monitor;

    localparam int W     = 3;
    localparam int LOCKN = 4;
    localparam int EW    = 2;
    localparam int EMAX  = (1 << EW) - 1;
    localparam int MODN  = 1 << W;
`ifdef GRAY_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  gray_in;
    logic          clr_err;
    logic [W-1:0]  bin_out;
    logic          bin_valid;
    logic          step_fwd;
    logic          step_rev;
    logic          step_err;
    logic          locked;
    logic [EW-1:0] err_cnt;
    logic [1:0]    state_out;

    int n_cmp = 0;
    int n_bad = 0;

    gray_step_monitor #(.WIDTH(W), .LOCK_COUNT(LOCKN), .ERR_CNT_W(EW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .gray_in   (gray_in),
        .clr_err   (clr_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_fwd  (step_fwd),
        .step_rev  (step_rev),
        .step_err  (step_err),
        .locked    (locked),
        .err_cnt   (err_cnt),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for first sample, 1 acquiring, 2 locked, 3 faulted.
    typedef struct {
        int mode;
        int pos;
        int good;
        int errs;
        bit bv;
        bit fwd;
        bit rev;
        bit serr;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t cur, bit v, int g, bit clr);
        model_t n;
        int b;
        int d;
        bit bad;
        n      = cur;
        n.bv   = 0;
        n.fwd  = 0;
        n.rev  = 0;
        n.serr = 0;
        bad    = 0;
        if (v) begin
            // binary value = XOR of all right shifts of the Gray value
            b = 0;
            for (int s = 0; s < W; s++) b = b ^ (g >> s);
            d = ((b - cur.pos) % MODN + MODN) % MODN;
            n.pos = b;
            n.bv  = 1;
            if (cur.mode == 0 || cur.mode == 3) begin
                n.mode = 1;
                n.good = 0;
            end else if (d == 0) begin
                // hold
            end else if (d == 1 || (d == MODN - 1 && BIDIR)) begin
                n.fwd = (d == 1);
                n.rev = (d == MODN - 1);
                if (cur.mode == 1) begin
                    n.good = cur.good + 1;
                    if (n.good == LOCKN) n.mode = 2;
                end
            end else begin
                bad = 1;
                if (cur.mode == 1) n.good = 0;
                else               n.mode = 3;
            end
        end
        n.serr = bad;
        if (clr)      n.errs = bad ? 1 : 0;
        else if (bad) n.errs = (cur.errs + 1 > EMAX) ? EMAX : cur.errs + 1;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        else       m <= model_next(m, in_valid, int'(gray_in), clr_err);
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("m_bin_out",   32'(bin_out),   32'(m.pos));
        check("m_bin_valid", 32'(bin_valid), 32'(m.bv));
        check("m_step_fwd",  32'(step_fwd),  32'(m.fwd));
        check("m_step_rev",  32'(step_rev),  32'(m.rev));
        check("m_step_err",  32'(step_err),  32'(m.serr));
        check("m_locked",    32'(locked),    32'(m.mode == 2));
        check("m_err_cnt",   32'(err_cnt),   32'(m.errs));
        check("m_state",     32'(state_out), 32'(m.mode));
    end

    // ---------------- directed stimulus ----------------
    // Called at posedge+1: present one valid sample for exactly one cycle.
    task automatic smp(input logic [W-1:0] g, input logic clr = 1'b0);
        in_valid = 1'b1;
        gray_in  = g;
        clr_err  = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Literal expectations for the sample just taken.
    task automatic exp_out(input string tag, input int b, input int fwd, input int serr,
                           input int st, input int e);
        check({tag, "_bin"},   32'(bin_out),   32'(b));
        check({tag, "_bv"},    32'(bin_valid), 32'd1);
        check({tag, "_fwd"},   32'(step_fwd),  32'(fwd));
        check({tag, "_serr"},  32'(step_err),  32'(serr));
        check({tag, "_state"}, 32'(state_out), 32'(st));
        check({tag, "_lock"},  32'(locked),    32'(st == 2));
        check({tag, "_err"},   32'(err_cnt),   32'(e));
    endtask

    task automatic exp_zero(input string tag);
        check({tag, "_bin"},   32'(bin_out),   32'd0);
        check({tag, "_bv"},    32'(bin_valid), 32'd0);
        check({tag, "_fwd"},   32'(step_fwd),  32'd0);
        check({tag, "_rev"},   32'(step_rev),  32'd0);
        check({tag, "_serr"},  32'(step_err),  32'd0);
        check({tag, "_lock"},  32'(locked),    32'd0);
        check({tag, "_err"},   32'(err_cnt),   32'd0);
        check({tag, "_state"}, 32'(state_out), 32'd0);
    endtask

    initial begin
        int e_rev;
        int st_mid;
        reset    = 1'b1;
        in_valid = 1'b0;
        gray_in  = '0;
        clr_err  = 1'b0;
        #2;
        exp_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Lock-up: 000,001,011,010,110 -> bin 0..4, locked after the fifth.
        smp(3'b000); exp_out("up0", 0, 0, 0, 1, 0);
        smp(3'b001); exp_out("up1", 1, 1, 0, 1, 0);
        smp(3'b011); exp_out("up2", 2, 1, 0, 1, 0);
        smp(3'b010); exp_out("up3", 3, 1, 0, 1, 0);
        smp(3'b110); exp_out("up4", 4, 1, 0, 2, 0);

        // Wrap: 5,6,7,0 all forward while locked.
        smp(3'b111); exp_out("wr5", 5, 1, 0, 2, 0);
        smp(3'b101); exp_out("wr6", 6, 1, 0, 2, 0);
        smp(3'b100); exp_out("wr7", 7, 1, 0, 2, 0);
        smp(3'b000); exp_out("wr0", 0, 1, 0, 2, 0);

        // Skip: locked at bin 3, then bin 5 is illegal -> FAULT; next re-seeds.
        smp(3'b001); smp(3'b011);
        smp(3'b010); exp_out("sk3", 3, 1, 0, 2, 0);
        smp(3'b111); exp_out("sk5", 5, 0, 1, 3, 1);
        smp(3'b101); exp_out("sk6", 6, 0, 0, 1, 1);

        // Relock from bin 6: 7,0,1,2 -> four good steps.
        smp(3'b100); smp(3'b000); smp(3'b001);
        smp(3'b011); exp_out("rl2", 2, 1, 0, 2, 1);
        smp(3'b010); exp_out("rl3", 3, 1, 0, 2, 1);

        // Reverse: bin 3 -> bin 2.
        e_rev  = BIDIR ? 1 : 2;
        st_mid = BIDIR ? 2 : 1;
        smp(3'b011);
        exp_out("rev", 2, 0, BIDIR ? 0 : 1, BIDIR ? 2 : 3, e_rev);
        check("rev_pulse", 32'(step_rev), 32'(BIDIR));

        // Back to LOCKED at bin 6 either way (hold or re-seed, then 3,4,5,6).
        smp(3'b011); exp_out("rs2", 2, 0, 0, st_mid, e_rev);
        smp(3'b010); smp(3'b110); smp(3'b111);
        smp(3'b101); exp_out("rs6", 6, 1, 0, 2, e_rev);

        // Hold and gap.
        smp(3'b101); exp_out("hold", 6, 0, 0, 2, e_rev);
        idle(3);
        check("gap_bv",    32'(bin_valid), 32'd0);
        check("gap_bin",   32'(bin_out),   32'd6);
        check("gap_fwd",   32'(step_fwd),  32'd0);
        check("gap_state", 32'(state_out), 32'd2);
        check("gap_err",   32'(err_cnt),   32'(e_rev));

        // Saturation: clear, then five illegal steps on a 2-bit counter.
        smp(3'b101, 1'b1); exp_out("clr",  6, 0, 0, 2, 0);
        smp(3'b000); exp_out("sat1", 0, 0, 1, 3, 1);
        smp(3'b000); exp_out("seed", 0, 0, 0, 1, 1);
        smp(3'b110); exp_out("sat2", 4, 0, 1, 1, 2);
        smp(3'b000); exp_out("sat3", 0, 0, 1, 1, 3);
        smp(3'b110); exp_out("sat4", 4, 0, 1, 1, 3);
        smp(3'b000); exp_out("sat5", 0, 0, 1, 1, 3);
        smp(3'b110, 1'b1); exp_out("clr_hit", 4, 0, 1, 1, 1);

        // Relock from bin 4, then reset asynchronously mid-cycle.
        smp(3'b111); smp(3'b101); smp(3'b100);
        smp(3'b000); exp_out("rl_b", 0, 1, 0, 2, 1);
        #2;
        reset = 1'b1;
        #1;
        exp_zero("arst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        smp(3'b011); exp_out("post", 2, 0, 0, 1, 0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
